// File: rtl/adaboost_weak_learner.sv
// adaboost_weak_learner
// One AdaBoost weak learner. It holds a signed weight memory and computes
// sign(sum_k data_k * w_k + bias) over NFEAT ternary features. The result is
// reported as +1 or -1.
//
// Ports
//   clk        clock; all state changes on the rising edge
//   rst        asynchronous, active-low reset
//   en         start request, sampled in IDLE
//   write      weight write strobe (ignored while accumulating)
//   read       weight readback strobe (ignored while accumulating)
//   address    write/readback address
//   weight_in  signed weight to write
//   weight_out registered readback data
//   load_done  sticky flag: the last entry (NFEAT-1) has been written
//   data       feature: 01 = +1, 11 = -1, 00/10 = 0
//   bias       signed bias, sign-extended into the accumulator
//   result     00 = busy/none, 01 = +1 class, 11 = -1 class
//   ready      high while result is valid
module adaboost_weak_learner #(
  parameter int unsigned NFEAT = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned WW    = 9,
  parameter int unsigned ACCW  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 write,
  input  logic                 read,
  input  logic [AW-1:0]        address,
  input  logic signed [WW-1:0] weight_in,
  output logic signed [WW-1:0] weight_out,
  output logic                 load_done,
  input  logic [1:0]           data,
  input  logic signed [WW-1:0] bias,
  output logic [1:0]           result,
  output logic                 ready
);

  typedef enum logic [1:0] {StIdle, StAccum, StBias, StDone} state_e;

  state_e                 state_q, state_d;
  logic [AW-1:0]          k_q, k_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic [1:0]             result_q, result_d;
  logic                   ready_q, ready_d;
  logic signed [WW-1:0]   weight_out_q;
  logic                   load_done_q;

  logic signed [WW-1:0]   mem [NFEAT];

  logic                   in_accum;
  logic                   mem_we;
  logic signed [WW-1:0]   w_k;
  logic signed [ACCW-1:0] w_ext, bias_ext, prod, sum;

  // The memory port is owned by the classifier while accumulating.
  assign in_accum = (state_q == StAccum);
  assign mem_we   = write && !in_accum;

  assign w_k      = mem[k_q];
  assign w_ext    = {{(ACCW-WW){w_k[WW-1]}}, w_k};
  assign bias_ext = {{(ACCW-WW){bias[WW-1]}}, bias};
  assign sum      = acc_q + bias_ext;

  // Ternary feature times weight: only 01 and 11 contribute.
  always_comb begin
    prod = '0;
    case (data)
      2'b01:   prod = w_ext;
      2'b11:   prod = -w_ext;
      default: prod = '0;
    endcase
  end

  // Weight storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[address] <= weight_in;
    end
  end

  // Readback sees the pre-write value when read and write hit the same address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      weight_out_q <= '0;
      load_done_q  <= 1'b0;
    end else begin
      if (read && !in_accum) begin
        weight_out_q <= mem[address];
      end
      if (mem_we && (address == AW'(NFEAT - 1))) begin
        load_done_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      k_q      <= '0;
      acc_q    <= '0;
      result_q <= 2'b00;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    acc_d    = acc_q;
    result_d = result_q;
    ready_d  = ready_q;
    unique case (state_q)
      StIdle: begin
        if (en) begin
          state_d  = StAccum;
          k_d      = '0;
          acc_d    = '0;
          result_d = 2'b00;
          ready_d  = 1'b0;
        end
      end
      StAccum: begin
        acc_d = acc_q + prod;
        k_d   = k_q + 1'b1;
        if (k_q == AW'(NFEAT - 1)) begin
          state_d = StBias;
        end
      end
      StBias: begin
        // A sum of exactly zero classifies as +1.
        result_d = sum[ACCW-1] ? 2'b11 : 2'b01;
        ready_d  = 1'b1;
        state_d  = StDone;
      end
      StDone: begin
        if (!en) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign weight_out = weight_out_q;
  assign load_done  = load_done_q;
  assign result     = result_q;
  assign ready      = ready_q;

endmodule

// File: tb/tb_adaboost_weak_learner.sv
// Scoreboard bench for adaboost_weak_learner: the driver pushes expected
// classifications and readback values into queues; a monitor pops and compares
// whenever the DUT presents a new result or a readback completes.
module tb_adaboost_weak_learner;

  logic              clk = 1'b0;
  logic              rst, en, write, read;
  logic [4:0]        address;
  logic signed [8:0] weight_in, bias, weight_out;
  logic [1:0]        data, result;
  logic              load_done, ready;

  int vectors = 0;
  int miscompares = 0;

  int         model_mem [32];
  int         model_ld;
  logic [1:0] run_data [32];
  logic [1:0] res_q [$];
  int         rd_q [$];
  bit         rd_seen;
  bit         rdy_prev;

  adaboost_weak_learner dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .write      (write),
    .read       (read),
    .address    (address),
    .weight_in  (weight_in),
    .weight_out (weight_out),
    .load_done  (load_done),
    .data       (data),
    .bias       (bias),
    .result     (result),
    .ready      (ready)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: readbacks land on the edge where read was sampled; a result is
  // presented on each rising edge of ready.
  initial begin
    rd_seen  = 1'b0;
    rdy_prev = 1'b0;
    forever begin
      @(posedge clk);
      rd_seen = read;
      @(negedge clk);
      if (rd_seen) begin
        if (rd_q.size() == 0) check("readback_unexpected", 1, 0);
        else check("readback", int'(weight_out), rd_q.pop_front());
      end
      if (ready && !rdy_prev) begin
        if (res_q.size() == 0) check("result_unexpected", 1, 0);
        else check("result", int'(result), int'(res_q.pop_front()));
      end
      rdy_prev = ready;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_w(input int a, input int w);
    address   = 5'(a);
    weight_in = 9'(w);
    write     = 1'b1;
    step();
    write     = 1'b0;
    model_mem[a] = w;
    if (a == 31) model_ld = 1;
  endtask

  task automatic read_w(input int a);
    address = 5'(a);
    read    = 1'b1;
    rd_q.push_back(model_mem[a]);
    step();
    read    = 1'b0;
  endtask

  // Reference: plain signed dot product plus bias, sign with tie -> +1.
  function automatic logic [1:0] model_class(input int b);
    int s;
    s = b;
    for (int k = 0; k < 32; k++) begin
      if (run_data[k] == 2'b01) s += model_mem[k];
      else if (run_data[k] == 2'b11) s -= model_mem[k];
    end
    return (s >= 0) ? 2'b01 : 2'b11;
  endfunction

  // One classification. wr_at > 0 issues a write to address 7 before that
  // accumulation edge; the model memory is left unchanged.
  task automatic run(input int b, input int wr_at);
    bit busy_bad;
    int n;
    busy_bad = 1'b0;
    res_q.push_back(model_class(b));
    bias = 9'(b);
    en   = 1'b1;
    step();
    en   = 1'b0;
    data = run_data[0];
    for (int i = 1; i <= 32; i++) begin
      if (i == wr_at) begin
        address   = 5'd7;
        weight_in = 9'(model_mem[7] + 77);
        write     = 1'b1;
      end
      step();
      write = 1'b0;
      if (result != 2'b00 || ready) busy_bad = 1'b1;
      if (i < 32) data = run_data[i];
    end
    check("busy_during_accum", int'(busy_bad), 0);
    n = 0;
    do begin
      step();
      n++;
    end while (!ready && n < 4);
    check("ready_after_e33", int'(ready), 1);
    check("ready_latency", n, 1);
    step();
  endtask

  task automatic fill(input int w);
    for (int a = 0; a < 32; a++) write_w(a, w);
  endtask

  task automatic set_data(input logic [1:0] d);
    for (int k = 0; k < 32; k++) run_data[k] = d;
  endtask

  initial begin
    en = 1'b0; write = 1'b0; read = 1'b0; address = '0;
    weight_in = '0; bias = '0; data = '0; model_ld = 0;
    for (int k = 0; k < 32; k++) model_mem[k] = 0;
    rst = 1'b1;
    #2 rst = 1'b0;
    #5;
    check("reset_result", int'(result), 0);
    check("reset_ready", int'(ready), 0);
    check("reset_weight_out", int'(weight_out), 0);
    check("reset_load_done", int'(load_done), 0);
    step();
    rst = 1'b1;
    step();

    // Load all ones; load_done only after the address-31 write.
    for (int a = 0; a < 31; a++) write_w(a, 1);
    check("load_done_before_last", int'(load_done), 0);
    write_w(31, 1);
    check("load_done_after_last", int'(load_done), 1);
    read_w(5);

    set_data(2'b01);
    run(0, 0);
    set_data(2'b11);
    run(0, 0);

    // Extreme weights: no accumulator overflow.
    fill(-256);
    set_data(2'b01);
    run(-256, 0);
    set_data(2'b11);
    run(255, 0);

    // Exact tie classifies +1; all-zero features with negative bias -> -1.
    fill(3);
    for (int k = 0; k < 32; k++) run_data[k] = (k < 16) ? 2'b01 : 2'b11;
    run(0, 0);
    for (int k = 0; k < 32; k++) run_data[k] = (k % 2 == 0) ? 2'b00 : 2'b10;
    run(-1, 0);

    // Same-address read and write in one cycle returns the old value.
    address   = 5'd9;
    weight_in = 9'sd100;
    write     = 1'b1;
    read      = 1'b1;
    rd_q.push_back(model_mem[9]);
    step();
    write = 1'b0;
    read  = 1'b0;
    model_mem[9] = 100;
    read_w(9);

    // Reset in the middle of a run.
    set_data(2'b01);
    bias = '0;
    en   = 1'b1;
    step();
    en   = 1'b0;
    for (int i = 1; i <= 10; i++) step();
    rst = 1'b0;
    #1;
    check("abort_result", int'(result), 0);
    check("abort_ready", int'(ready), 0);
    check("abort_weight_out", int'(weight_out), 0);
    check("abort_load_done", int'(load_done), 0);
    model_ld = 0;
    step();
    rst = 1'b1;
    begin
      bit rdy_seen;
      rdy_seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
        step();
        if (ready) rdy_seen = 1'b1;
      end
      check("abort_stays_idle", int'(rdy_seen), 0);
    end
    for (int k = 0; k < 32; k++) run_data[k] = 2'($urandom_range(3));
    run(int'($urandom_range(40)) - 20, 0);

    // Write attempted during accumulation must not touch memory.
    for (int k = 0; k < 32; k++) run_data[k] = 2'($urandom_range(3));
    run(0, 5);
    read_w(7);
    check("load_done_after_abort", int'(load_done), model_ld);

    // Randomized runs.
    for (int it = 0; it < 20; it++) begin
      for (int a = 0; a < 32; a++) write_w(a, int'($urandom_range(511)) - 256);
      check("load_done_random", int'(load_done), model_ld);
      read_w(int'($urandom_range(31)));
      for (int k = 0; k < 32; k++) run_data[k] = 2'($urandom_range(3));
      run(int'($urandom_range(511)) - 256, 0);
    end

    step();
    step();
    check("scoreboard_drained", res_q.size() + rd_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
